// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the NN address sequencer.
// Holds the FSM state encoding, the default parameter values and a width helper.
// No logic of its own: it is imported by the interface, the counter and the top.
package nn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BOOT = 2'd2,
        FIN  = 2'd3
    } seq_state_t;

    localparam int DEF_DEPTH       = 100;
    localparam int DEF_K           = 502;
    localparam int DEF_LANES       = 2;
    localparam int DEF_NN_OUT      = 10;
    localparam int DEF_BOOT_EVERY  = 4;
    localparam int DEF_BOOT_CYCLES = 10;

    // Bit width able to index 0..x-1, never narrower than one bit.
    function automatic int clog2_min1(input int x);
        int r;
        r = $clog2(x);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nn_addr_sequencer_if.sv
// Control/address bundle between the sequencer, its controller and the BRAM read ports.
// master = controller/consumer side, slave = sequencer side.
// boot_done_in exists only when NN_ADDR_SEQ_BOOT_HANDSHAKE_EN is defined.
interface nn_addr_sequencer_if
    import nn_seq_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int K      = DEF_K,
    parameter int LANES  = DEF_LANES,
    parameter int NN_OUT = DEF_NN_OUT
) ();

    localparam int KL = K / LANES;
    localparam int NW = clog2_min1(DEPTH);
    localparam int KW = clog2_min1(KL);
    localparam int JW = clog2_min1(NN_OUT);
    localparam int AW = clog2_min1(DEPTH * KL);
    localparam int PW = clog2_min1(DEPTH * NN_OUT);
    localparam int BW = clog2_min1(NN_OUT * KL);

    logic          start_in;
    logic          out_ready_in;
`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
    logic          boot_done_in;
`endif
    logic          addr_valid_out;
    logic [NW-1:0] outer_n_out;
    logic [KW-1:0] k_out;
    logic [JW-1:0] nn_out;
    logic [AW-1:0] a_addr_out;
    logic [PW-1:0] nn_addr_out;
    logic [BW-1:0] b_addr_out;
    logic          boot_out;
    logic          busy_out;
    logic          done_out;

    modport master (
`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
        output boot_done_in,
`endif
        output start_in, out_ready_in,
        input  addr_valid_out, outer_n_out, k_out, nn_out,
        input  a_addr_out, nn_addr_out, b_addr_out,
        input  boot_out, busy_out, done_out
    );

    modport slave (
`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
        input  boot_done_in,
`endif
        input  start_in, out_ready_in,
        output addr_valid_out, outer_n_out, k_out, nn_out,
        output a_addr_out, nn_addr_out, b_addr_out,
        output boot_out, busy_out, done_out
    );

endinterface

// File: rtl/nn_wrap_counter.sv
// Modulo-MAX up-counter with synchronous clear; wrap flags the step from MAX-1 back to 0.
// Count updates one cycle after en; wrap is combinational (en & count==MAX-1).
// No handshake: the parent gates en, and clr takes priority over en.
module nn_wrap_counter
    import nn_seq_pkg::*;
#(
    parameter int MAX = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         clr,
    input  logic                         en,
    output logic [clog2_min1(MAX)-1:0]   count,
    output logic                         wrap
);

    localparam int W = clog2_min1(MAX);

    assign wrap = en & (count == W'(MAX - 1));

    // Count register: clear, wrap to zero at MAX-1, otherwise increment when enabled.
    always_ff @(posedge clk_in) begin
        if (rst_in || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/nn_addr_sequencer.sv
// Walks rows n, LWE words k and neurons j (j innermost) and issues registered A/NN/b addresses.
// One cycle from start to the first valid tuple; a new tuple follows every accepted cycle.
// Holds the tuple while out_ready_in is low; bootstrap pauses drop valid (boot_done_in handshake if NN_ADDR_SEQ_BOOT_HANDSHAKE_EN).
module nn_addr_sequencer
    import nn_seq_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int K           = DEF_K,
    parameter int LANES       = DEF_LANES,
    parameter int NN_OUT      = DEF_NN_OUT,
    parameter int BOOT_EVERY  = DEF_BOOT_EVERY,
    parameter int BOOT_CYCLES = DEF_BOOT_CYCLES
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    nn_addr_sequencer_if.slave   bus
);

    localparam int KL = K / LANES;
    localparam int NW = clog2_min1(DEPTH);
    localparam int KW = clog2_min1(KL);
    localparam int JW = clog2_min1(NN_OUT);
    localparam int AW = clog2_min1(DEPTH * KL);
    localparam int PW = clog2_min1(DEPTH * NN_OUT);
    localparam int BW = clog2_min1(NN_OUT * KL);

    seq_state_t    state;
    seq_state_t    state_nx;

    logic          load;
    logic          accept;
    logic          boot_row;
    logic          boot_exit;

    logic [JW-1:0] j_cnt;
    logic [KW-1:0] k_cnt;
    logic [NW-1:0] n_cnt;
    logic          j_wrap;
    logic          k_wrap;
    logic          n_wrap;

    logic [JW-1:0] j_nx;
    logic [KW-1:0] k_nx;
    logic [NW-1:0] n_nx;

    logic          valid_q;
    logic          boot_q;
    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] a_addr_q;
    logic [PW-1:0] nn_addr_q;
    logic [BW-1:0] b_addr_q;

    assign load   = (state == IDLE) & bus.start_in;
    assign accept = (state == RUN) & valid_q & bus.out_ready_in;

    // Row n just finished is a bootstrap row when (n+1) is a multiple of BOOT_EVERY.
    assign boot_row = ((int'(n_cnt) + 1) % BOOT_EVERY) == 0;

    // j steps on every accept, k when j wraps, n when k wraps; wrap includes en so the chain gates itself.
    nn_wrap_counter #(.MAX(NN_OUT)) u_j_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (load),
        .en     (accept),
        .count  (j_cnt),
        .wrap   (j_wrap)
    );

    nn_wrap_counter #(.MAX(KL)) u_k_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (load),
        .en     (j_wrap),
        .count  (k_cnt),
        .wrap   (k_wrap)
    );

    nn_wrap_counter #(.MAX(DEPTH)) u_n_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (load),
        .en     (k_wrap),
        .count  (n_cnt),
        .wrap   (n_wrap)
    );

`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
    // Pause ends on the first sampled boot_done_in while in BOOT, so it always lasts at least one cycle.
    assign boot_exit = bus.boot_done_in;
`else
    logic [clog2_min1(BOOT_CYCLES)-1:0] boot_cnt;
    logic                               boot_wrap;

    nn_wrap_counter #(.MAX(BOOT_CYCLES)) u_boot_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (load),
        .en     (state == BOOT),
        .count  (boot_cnt),
        .wrap   (boot_wrap)
    );

    assign boot_exit = boot_wrap;

    // The timer wraps on the last pause cycle, so it must be parked at zero outside BOOT.
    boot_cnt_parked: assert property (@(posedge clk_in) disable iff (rst_in)
        (state != BOOT) |-> (boot_cnt == '0));
`endif

    // Counter values after this edge; addresses are registered from these so they move with the handshake.
    always_comb begin
        j_nx = j_cnt;
        k_nx = k_cnt;
        n_nx = n_cnt;
        if (load) begin
            j_nx = '0;
            k_nx = '0;
            n_nx = '0;
        end else begin
            if (accept) j_nx = j_wrap ? '0 : j_cnt + JW'(1);
            if (j_wrap) k_nx = k_wrap ? '0 : k_cnt + KW'(1);
            if (k_wrap) n_nx = n_wrap ? '0 : n_cnt + NW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: the final accept goes to FIN, a bootstrap row end goes to BOOT.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start_in) state_nx = RUN;
            RUN: begin
                if (accept && n_wrap) begin
                    state_nx = FIN;
                end else if (accept && k_wrap && boot_row) begin
                    state_nx = BOOT;
                end
            end
            BOOT: if (boot_exit) state_nx = RUN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered status flags and addresses, decoded from the state being entered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q   <= 1'b0;
            boot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_addr_q  <= '0;
            nn_addr_q <= '0;
            b_addr_q  <= '0;
        end else begin
            valid_q   <= (state_nx == RUN);
            boot_q    <= (state_nx == BOOT);
            busy_q    <= (state_nx == RUN) || (state_nx == BOOT);
            done_q    <= (state_nx == FIN);
            a_addr_q  <= AW'(n_nx) * AW'(KL) + AW'(k_nx);
            nn_addr_q <= PW'(n_nx) * PW'(NN_OUT) + PW'(j_nx);
            b_addr_q  <= BW'(j_nx) * BW'(KL) + BW'(k_nx);
        end
    end

    assign bus.addr_valid_out = valid_q;
    assign bus.outer_n_out    = n_cnt;
    assign bus.k_out          = k_cnt;
    assign bus.nn_out         = j_cnt;
    assign bus.a_addr_out     = a_addr_q;
    assign bus.nn_addr_out    = nn_addr_q;
    assign bus.b_addr_out     = b_addr_q;
    assign bus.boot_out       = boot_q;
    assign bus.busy_out       = busy_q;
    assign bus.done_out       = done_q;

endmodule

// File: tb/tb_nn_addr_sequencer.sv
// Directed bench for nn_addr_sequencer at DEPTH=4, K=4, LANES=2, NN_OUT=3, BOOT_EVERY=2, BOOT_CYCLES=3.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Expected tuples come from a loop-nest model; key tuples are also checked against hand-computed values.
module tb_nn_addr_sequencer;

    localparam int DEPTH = 4, K = 4, LANES = 2, NN_OUT = 3, BOOT_EVERY = 2, BOOT_CYCLES = 3;
    localparam int KL = 2;
    localparam int NTUP = 24;
`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
    localparam int EXP_BOOT = 7;
`else
    localparam int EXP_BOOT = BOOT_CYCLES;
`endif

    typedef struct {
        int n, k, j, a, nn, b, cyc;
    } tup_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    tup_t acc_q[$];
    int   boot_lens[$];
    int   boot_start[$];
    int   done_cyc, unstable, boot_valid_bad, busy_bad, busy_at_done;

    always #5 clk = ~clk;

    nn_addr_sequencer_if #(.DEPTH(DEPTH), .K(K), .LANES(LANES), .NN_OUT(NN_OUT)) bus ();

    nn_addr_sequencer #(
        .DEPTH(DEPTH), .K(K), .LANES(LANES), .NN_OUT(NN_OUT),
        .BOOT_EVERY(BOOT_EVERY), .BOOT_CYCLES(BOOT_CYCLES)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference tuple for accept number idx, straight from the n/k/j loop nest.
    function automatic tup_t model(input int idx);
        tup_t t;
        t.n   = idx / (KL * NN_OUT);
        t.k   = (idx / NN_OUT) % KL;
        t.j   = idx % NN_OUT;
        t.a   = t.n * KL + t.k;
        t.nn  = t.n * NN_OUT + t.j;
        t.b   = t.j * KL + t.k;
        t.cyc = 0;
        return t;
    endfunction

    function automatic tup_t sample(input int cyc);
        tup_t t;
        t.n   = int'(bus.outer_n_out);
        t.k   = int'(bus.k_out);
        t.j   = int'(bus.nn_out);
        t.a   = int'(bus.a_addr_out);
        t.nn  = int'(bus.nn_addr_out);
        t.b   = int'(bus.b_addr_out);
        t.cyc = cyc;
        return t;
    endfunction

    function automatic bit same(input tup_t x, input tup_t y);
        return x.n == y.n && x.k == y.k && x.j == y.j && x.a == y.a && x.nn == y.nn && x.b == y.b;
    endfunction

    task automatic start_run();
        @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        chk("start_latency_valid", bus.addr_valid_out, 1);
        chk("start_busy", bus.busy_out, 1);
    endtask

    // Record accepts, pauses and done until the done pulse. ready_mode 0: ready=1, 1: 1-0-0 pattern.
    task automatic capture(input int ready_mode, input bit busy_starts, input bit start_on_done);
        int   cyc = 0;
        int   cur_boot = 0;
        bit   stalled = 0;
        bit   r;
        tup_t cur, prev;
        acc_q.delete(); boot_lens.delete(); boot_start.delete();
        done_cyc = -1; unstable = 0; boot_valid_bad = 0; busy_bad = 0; busy_at_done = -1;
        prev = sample(0);
        while (1) begin
            cur = sample(cyc);
            if (stalled && !same(cur, prev)) unstable++;
            if (bus.boot_out) begin
                if (cur_boot == 0) boot_start.push_back(cyc);
                cur_boot++;
                if (bus.addr_valid_out) boot_valid_bad++;
            end else if (cur_boot != 0) begin
                boot_lens.push_back(cur_boot);
                cur_boot = 0;
            end
`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
            bus.boot_done_in = bus.boot_out && (cur_boot == 7);
`endif
            r = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            bus.out_ready_in = r;
            bus.start_in = busy_starts && (cyc == 5 || cyc == 13);
            if (!bus.done_out && !bus.busy_out) busy_bad++;
            if (bus.addr_valid_out && r) acc_q.push_back(cur);
            stalled = bus.addr_valid_out && !r;
            prev = cur;
            if (bus.done_out) begin
                done_cyc = cyc;
                busy_at_done = int'(bus.busy_out);
                bus.start_in = start_on_done;
                break;
            end
            if (cyc >= 400) begin
                chk("capture_timeout", 1, 0);
                break;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string p, input bit full_ready);
        int mism = 0;
        chk({p, "_count"}, acc_q.size(), NTUP);
        foreach (acc_q[i]) if (!same(acc_q[i], model(i))) mism++;
        chk({p, "_seq_mismatch"}, mism, 0);
        chk({p, "_stable_when_stalled"}, unstable, 0);
        chk({p, "_valid_in_boot"}, boot_valid_bad, 0);
        chk({p, "_busy_during_run"}, busy_bad, 0);
        chk({p, "_busy_at_done"}, busy_at_done, 0);
        chk({p, "_boot_count"}, boot_lens.size(), 1);
        if (boot_lens.size() >= 1) chk({p, "_boot_len"}, boot_lens[0], EXP_BOOT);
        if (acc_q.size() == NTUP) begin
            chk({p, "_t1_abn"}, {acc_q[0].a[7:0], acc_q[0].nn[7:0], acc_q[0].b[7:0]}, 0);
            chk({p, "_t2_j"}, acc_q[1].j, 1);
            chk({p, "_t2_nn"}, acc_q[1].nn, 1);
            chk({p, "_t2_b"}, acc_q[1].b, 2);
            chk({p, "_t4_k"}, acc_q[3].k, 1);
            chk({p, "_t4_a"}, acc_q[3].a, 1);
            chk({p, "_t4_b"}, acc_q[3].b, 1);
            chk({p, "_t13_n"}, acc_q[12].n, 2);
            chk({p, "_t13_kj"}, acc_q[12].k + acc_q[12].j, 0);
            chk({p, "_t13_a"}, acc_q[12].a, 4);
            chk({p, "_t13_nn"}, acc_q[12].nn, 6);
            chk({p, "_t24_a"}, acc_q[23].a, 7);
            chk({p, "_t24_nn"}, acc_q[23].nn, 11);
            chk({p, "_t24_b"}, acc_q[23].b, 5);
            chk({p, "_done_gap"}, done_cyc - acc_q[23].cyc, 1);
            if (boot_start.size() >= 1) chk({p, "_boot_after_t12"}, boot_start[0] - acc_q[11].cyc, 1);
            if (full_ready) chk({p, "_t13_after_boot"}, acc_q[12].cyc - acc_q[11].cyc, EXP_BOOT + 1);
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_valid"}, bus.addr_valid_out, 0);
        chk({p, "_boot"}, bus.boot_out, 0);
        chk({p, "_busy"}, bus.busy_out, 0);
        chk({p, "_done"}, bus.done_out, 0);
        chk({p, "_nkj"}, {bus.outer_n_out, bus.k_out, bus.nn_out}, 0);
        chk({p, "_addrs"}, {bus.a_addr_out, bus.nn_addr_out, bus.b_addr_out}, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        bus.start_in = 1'b0;
        bus.out_ready_in = 1'b0;
`ifdef NN_ADDR_SEQ_BOOT_HANDSHAKE_EN
        bus.boot_done_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        bus.out_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_valid", bus.addr_valid_out, 0);

        // Full-rate run.
        start_run();
        capture(0, 1'b0, 1'b0);
        check_run("run_ready1", 1'b1);
        @(negedge clk);
        chk("done_single_pulse", bus.done_out, 0);
        chk("idle_after_fin", bus.addr_valid_out, 0);

        // Backpressure in a 1-0-0 pattern.
        start_run();
        capture(1, 1'b0, 1'b0);
        check_run("run_ready100", 1'b0);

        // Reset while in BOOT, then restart.
        start_run();
        bus.out_ready_in = 1'b1;
        for (int i = 0; i < 100 && !bus.boot_out; i++) @(negedge clk);
        chk("reach_boot", bus.boot_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("mid_boot_reset");
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done_out || bus.addr_valid_out) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        start_run();
        capture(0, 1'b0, 1'b0);
        check_run("restart", 1'b1);

        // Starts while busy, start during FIN ignored, start one cycle later accepted.
        start_run();
        capture(0, 1'b1, 1'b1);
        check_run("busy_starts", 1'b1);
        @(negedge clk);
        chk("start_in_fin_ignored", bus.addr_valid_out, 0);
        chk("start_in_fin_not_busy", bus.busy_out, 0);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        chk("start_after_fin_valid", bus.addr_valid_out, 1);
        chk("start_after_fin_tuple", {bus.a_addr_out, bus.nn_addr_out, bus.b_addr_out}, 0);
        capture(0, 1'b0, 1'b0);
        check_run("second_run", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish before 300000");
        $fatal(1, "simulation time limit");
    end

endmodule
